// File: rtl/cpu_defs.sv
// Shared MDU definitions: operation encodings, FSM state encoding and default operand width.
package cpu_defs;

  localparam int MDU_WIDTH = 32;

  localparam logic MDU_MULT = 1'b0;
  localparam logic MDU_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit + datapath (master) and the MDU (slave).
// The sgn port exists only when MDU_UNSIGNED_EN is defined.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
`ifdef MDU_UNSIGNED_EN
  logic             sgn;
`endif
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MDU_UNSIGNED_EN
  modport master (output start, op, sgn, a, b, input busy, done, div0, hi, lo);
  modport slave  (input start, op, sgn, a, b, output busy, done, div0, hi, lo);
`else
  modport master (output start, op, a, b, input busy, done, div0, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div0, hi, lo);
`endif

endinterface

// File: rtl/mdu_addsub.sv
// W-bit add/subtract shared by the Booth step and the restoring-division trial subtract.
// cout_o is the raw carry; for subtraction it is 1 when a_i >= b_i (unsigned).
module mdu_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] b_x;

  assign b_x             = sub_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_x} + {{W{1'b0}}, sub_i};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) producing HI/LO; done WIDTH+1 cycles after start.
// Optional MDU_UNSIGNED_EN adds the sgn input for multu/divu.
module mult_div_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave mdu
);

  localparam int XW = WIDTH + 1;

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XW-1:0]    acc_q;   // Booth upper half / division remainder
  logic [WIDTH-1:0] mpl_q;   // Booth multiplier / dividend shifting into quotient
  logic [XW-1:0]    mcd_q;   // multiplicand / divisor magnitude
  logic             prev_q;
  logic             sa_q;
  logic             sb_q;
  logic             sgn_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last_step;

  logic [XW-1:0]    shl_rem;
  logic [XW-1:0]    add_a;
  logic             add_sub;
  logic [XW-1:0]    add_sum;
  logic             add_cout;
  logic             add_ext;
  logic [XW:0]      booth_wide;
  logic [XW-1:0]    booth_acc;
  logic [WIDTH-1:0] booth_mpl;
  logic [WIDTH-1:0] mul_hi;
  logic [XW-1:0]    div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

`ifdef MDU_UNSIGNED_EN
  assign sgn_in = mdu.sgn;
`else
  assign sgn_in = 1'b1;
`endif

  assign a_neg     = sgn_in & mdu.a[WIDTH-1];
  assign b_neg     = sgn_in & mdu.b[WIDTH-1];
  assign b_zero    = (mdu.b == '0);
  assign a_mag     = a_neg ? -mdu.a : mdu.a;
  assign b_mag     = b_neg ? -mdu.b : mdu.b;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Shared adder: Booth add/sub on the upper half in MULT, trial subtract in DIV.
  assign shl_rem = {acc_q[WIDTH-1:0], mpl_q[WIDTH-1]};
  assign add_a   = (state_q == DIV) ? shl_rem : acc_q;
  assign add_sub = (state_q == DIV) | (mpl_q[0] & ~prev_q);

  mdu_addsub #(.W(XW)) u_addsub (
    .a_i    (add_a),
    .b_i    (mcd_q),
    .sub_i  (add_sub),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // True sign of the XW+1-bit result, so the arithmetic shift survives an overflowing add.
  assign add_ext    = add_a[XW-1] ^ mcd_q[XW-1] ^ add_sub ^ add_cout;
  assign booth_wide = (mpl_q[0] == prev_q) ? {acc_q[XW-1], acc_q} : {add_ext, add_sum};
  assign booth_acc  = booth_wide[XW:1];
  assign booth_mpl  = {booth_wide[0], mpl_q[WIDTH-1:1]};

  always_comb begin
    mul_hi = booth_acc[WIDTH-1:0];
`ifdef MDU_UNSIGNED_EN
    // Zero-extended multiplier: top Booth pair (0, b[WIDTH-1]) adds the multiplicand at weight 2^WIDTH.
    if (!sgn_q && mpl_q[0]) begin
      mul_hi = booth_acc[WIDTH-1:0] + mcd_q[WIDTH-1:0];
    end
`endif
  end

  assign div_rem = add_cout ? add_sum : shl_rem;
  assign div_quo = {mpl_q[WIDTH-2:0], add_cout};
  assign div_lo  = (sgn_q & (sa_q ^ sb_q)) ? -div_quo : div_quo;
  assign div_hi  = (sgn_q & sa_q) ? -div_rem[WIDTH-1:0] : div_rem[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mpl_q   <= '0;
      mcd_q   <= '0;
      prev_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mdu.start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            prev_q <= 1'b0;
            acc_q  <= '0;
            sgn_q  <= sgn_in;
            if (mdu.op == MDU_MULT) begin
              mpl_q   <= mdu.b;
              mcd_q   <= {a_neg, mdu.a};
              state_q <= MULT;
            end else if (b_zero) begin
              done_q  <= 1'b1;
              div0_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              mpl_q   <= a_mag;
              mcd_q   <= {1'b0, b_mag};
              sa_q    <= a_neg;
              sb_q    <= b_neg;
              state_q <= DIV;
            end
          end
        end
        MULT: begin
          acc_q  <= booth_acc;
          mpl_q  <= booth_mpl;
          prev_q <= mpl_q[0];
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_step) begin
            hi_q    <= mul_hi;
            lo_q    <= booth_mpl;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        DIV: begin
          acc_q <= div_rem;
          mpl_q <= div_quo;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step) begin
            hi_q    <= div_hi;
            lo_q    <= div_lo;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.div0 = div0_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/div0 queued at issue, checked when done pulses.
module tb_mult_div_unit;
  import cpu_defs::*;

  localparam int W = MDU_WIDTH;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) mdu_if ();

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_if)
  );

  exp_t         sb_q[$];
  int           n_cmp  = 0;
  int           n_bad  = 0;
  logic [W-1:0] mdl_hi = '0;
  logic [W-1:0] mdl_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic op, input logic sgn,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == MDU_MULT) begin
      if (sgn) begin
        p = sa * sb;
        return p;
      end
      return ua * ub;
    end
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Issue one operation; poke >= 0 re-pulses start with junk operands in that cycle.
  task automatic run_op(input string tag, input logic op, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    exp_t        e;
    logic [63:0] r;
    int          k, busy_n, lat;
    logic        seen;
    if (op == MDU_DIV && b == '0) begin
      e.hi = mdl_hi; e.lo = mdl_lo; e.div0 = 1'b1; lat = 1;
    end else begin
      r = ref_op(op, sgn, a, b);
      e.hi = r[63:32]; e.lo = r[31:0]; e.div0 = 1'b0; lat = W + 1;
      mdl_hi = e.hi; mdl_lo = e.lo;
    end
    @(posedge clk); #1;
    mdu_if.start = 1'b1;
    mdu_if.op    = op;
    mdu_if.a     = a;
    mdu_if.b     = b;
`ifdef MDU_UNSIGNED_EN
    mdu_if.sgn   = sgn;
`endif
    @(negedge clk);
    chk({tag, "_busy_c0"}, 64'(mdu_if.busy), 64'd0);
    sb_q.push_back(e);
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    mdu_if.op    = ~op;
    mdu_if.a     = $urandom;
    mdu_if.b     = $urandom;
    k = 0; seen = 1'b0; busy_n = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (mdu_if.busy) busy_n++;
      if (mdu_if.done) begin
        seen = 1'b1;
        chk({tag, "_latency"}, 64'(k), 64'(lat));
      end
      if (k == poke) begin
        mdu_if.start = 1'b1;
        mdu_if.op    = 1'($urandom_range(0, 1));
        mdu_if.a     = $urandom;
        mdu_if.b     = $urandom;
      end else if (k == poke + 1) begin
        mdu_if.start = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat));
    @(negedge clk);
    mdu_if.start = 1'b0;
    chk({tag, "_idle_after"}, 64'(mdu_if.busy), 64'd0);
    @(negedge clk);
    chk({tag, "_still_idle"}, 64'(mdu_if.busy), 64'd0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && mdu_if.div0 && !mdu_if.done)
      chk("div0_without_done", 64'(mdu_if.div0), 64'd0);
    if (!reset && mdu_if.done) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 64'(mdu_if.done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_hi",   64'(mdu_if.hi),   64'(e.hi));
        chk("sb_lo",   64'(mdu_if.lo),   64'(e.lo));
        chk("sb_div0", 64'(mdu_if.div0), 64'(e.div0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d compares, expected completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop;
    mdu_if.start = 1'b0;
    mdu_if.op    = MDU_MULT;
    mdu_if.a     = '0;
    mdu_if.b     = '0;
`ifdef MDU_UNSIGNED_EN
    mdu_if.sgn   = 1'b1;
`endif
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(mdu_if.busy), 64'd0);
    chk("rst_done", 64'(mdu_if.done), 64'd0);
    chk("rst_div0", 64'(mdu_if.div0), 64'd0);
    chk("rst_hi",   64'(mdu_if.hi),   64'd0);
    chk("rst_lo",   64'(mdu_if.lo),   64'd0);
    reset = 1'b0;

    run_op("mul_7x-3",   MDU_MULT, 1'b1, 32'd7,         32'hFFFF_FFFD, -1);
    run_op("mul_min_sq", MDU_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 10);
    run_op("div_-7_2",   MDU_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,         -1);
    run_op("div_100_7",  MDU_DIV,  1'b1, 32'd100,       32'd7,         -1);
    run_op("div_by_0",   MDU_DIV,  1'b1, 32'd5,         32'd0,         -1);
    run_op("div_min_-1", MDU_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("mul_pokefin", MDU_MULT, 1'b1, 32'h1234_5678, 32'hFEDC_BA98, W + 1);
    run_op("div_7_-100", MDU_DIV,  1'b1, 32'd7,         32'hFFFF_FF9C, -1);

    for (int i = 0; i < 8; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = (i % 2 == 1) ? 32'($urandom_range(1, 100)) : $urandom;
      if (i == 5) rb = '0;
      if (i == 2) rb = -rb;
      run_op("rand", rop, 1'b1, ra, rb, -1);
    end

`ifdef MDU_UNSIGNED_EN
    run_op("multu_ffx2",  MDU_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2,         -1);
    run_op("divu_ff_2",   MDU_DIV,  1'b0, 32'hFFFF_FFFF, 32'd2,         -1);
    run_op("multu_ffxff", MDU_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("divu_big",    MDU_DIV,  1'b0, 32'hF000_0001, 32'h8000_0003, -1);
`endif

    chk("hold_hi", 64'(mdu_if.hi), 64'(mdl_hi));
    chk("hold_lo", 64'(mdu_if.lo), 64'(mdl_lo));

    // Reset during a division: everything clears at once and no done follows.
    @(posedge clk); #1;
    mdu_if.start = 1'b1;
    mdu_if.op    = MDU_DIV;
    mdu_if.a     = 32'd1000;
    mdu_if.b     = 32'd3;
`ifdef MDU_UNSIGNED_EN
    mdu_if.sgn   = 1'b1;
`endif
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_busy_before", 64'(mdu_if.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(mdu_if.busy), 64'd0);
    chk("abort_done", 64'(mdu_if.done), 64'd0);
    chk("abort_div0", 64'(mdu_if.div0), 64'd0);
    chk("abort_hi",   64'(mdu_if.hi),   64'd0);
    chk("abort_lo",   64'(mdu_if.lo),   64'd0);
    @(negedge clk);
    reset  = 1'b0;
    mdl_hi = '0;
    mdl_lo = '0;
    repeat (40) @(negedge clk);
    chk("abort_idle", 64'(mdu_if.busy), 64'd0);

    run_op("post_rst_div0", MDU_DIV,  1'b1, 32'd9,     32'd0,         -1);
    run_op("post_rst_mul",  MDU_MULT, 1'b1, 32'd12345, 32'hFFFF_FD5A, -1);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
